// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem
// Purpose  : EX -> MEM pipeline register of the 5-stage MIPS32 core.
//            Captures execute-stage results (GPR write, HI/LO write, load/store
//            opcode, address, store data). When EX is stalled but MEM is free,
//            a bubble is sent to MEM. The MADD/MSUB partial product and step
//            count are held here and fed back to EX on the following cycle.
// Ports    : clk, rst (async, active-low), stall[5:0] (bit3 = EX, bit4 = MEM),
//            flush, ex_* inputs -> mem_* registered outputs, mem_valid,
//            hilo_i/count_i -> hilo_o/count_o feedback.
// Option   : `define EX_MEM_BUBBLE_CNT_EN adds bubble_cnt_clr input and a
//            32-bit saturating bubble_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem #(
  parameter int ALUOP_W = 8,
  parameter int REG_W   = 32,
  parameter int RADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic                 ex_writeReg,
  input  logic [RADDR_W-1:0]   ex_writeAddr,
  input  logic [REG_W-1:0]     ex_writeData,
  input  logic                 ex_wHiLo,
  input  logic [REG_W-1:0]     ex_hiData,
  input  logic [REG_W-1:0]     ex_loData,
  input  logic [ALUOP_W-1:0]   ex_aluOp,
  input  logic [REG_W-1:0]     ex_mem_addr,
  input  logic [REG_W-1:0]     ex_opNum2,
  input  logic [2*REG_W-1:0]   hilo_i,
  input  logic [1:0]           count_i,
`ifdef EX_MEM_BUBBLE_CNT_EN
  input  logic                 bubble_cnt_clr,
  output logic [31:0]          bubble_cnt,
`endif
  output logic                 mem_writeReg,
  output logic [RADDR_W-1:0]   mem_writeAddr,
  output logic [REG_W-1:0]     mem_writeData,
  output logic                 mem_wHiLo,
  output logic [REG_W-1:0]     mem_hiData,
  output logic [REG_W-1:0]     mem_loData,
  output logic [ALUOP_W-1:0]   mem_aluOp,
  output logic [REG_W-1:0]     mem_mem_addr,
  output logic [REG_W-1:0]     mem_opNum2,
  output logic [2*REG_W-1:0]   hilo_o,
  output logic [1:0]           count_o,
  output logic                 mem_valid
);

  // Only the EX and MEM stall bits matter to this stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  logic load_bubble;  // flush, or EX stalled while MEM is free
  logic load_ex;      // EX advancing and not flushed
  logic keep_madd;    // bubble caused by an EX stall: keep partial product

  always_comb begin
    load_bubble = flush | (stall[3] & ~stall[4]);
    load_ex     = ~flush & ~stall[3];
    keep_madd   = ~flush & stall[3] & ~stall[4];
  end

  // MEM slot. Bubbles clear every field so no stale enable reaches MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_writeReg  <= 1'b0;
      mem_writeAddr <= '0;
      mem_writeData <= '0;
      mem_wHiLo     <= 1'b0;
      mem_hiData    <= '0;
      mem_loData    <= '0;
      mem_aluOp     <= '0;
      mem_mem_addr  <= '0;
      mem_opNum2    <= '0;
      mem_valid     <= 1'b0;
    end else if (load_bubble) begin
      mem_writeReg  <= 1'b0;
      mem_writeAddr <= '0;
      mem_writeData <= '0;
      mem_wHiLo     <= 1'b0;
      mem_hiData    <= '0;
      mem_loData    <= '0;
      mem_aluOp     <= '0;
      mem_mem_addr  <= '0;
      mem_opNum2    <= '0;
      mem_valid     <= 1'b0;
    end else if (load_ex) begin
      mem_writeReg  <= ex_writeReg;
      mem_writeAddr <= ex_writeAddr;
      mem_writeData <= ex_writeData;
      mem_wHiLo     <= ex_wHiLo;
      mem_hiData    <= ex_hiData;
      mem_loData    <= ex_loData;
      mem_aluOp     <= ex_aluOp;
      mem_mem_addr  <= ex_mem_addr;
      mem_opNum2    <= ex_opNum2;
      mem_valid     <= 1'b1;
    end
    // EX and MEM both stalled: hold.
  end

  // MADD/MSUB feedback: kept only across an EX stall, cleared once EX
  // advances or the slot is flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_o  <= '0;
      count_o <= 2'b00;
    end else if (keep_madd) begin
      hilo_o  <= hilo_i;
      count_o <= count_i;
    end else if (flush | load_ex) begin
      hilo_o  <= '0;
      count_o <= 2'b00;
    end
  end

`ifdef EX_MEM_BUBBLE_CNT_EN
  // Saturating count of edges that inserted a bubble; clear beats increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= 32'd0;
    end else if (bubble_cnt_clr) begin
      bubble_cnt <= 32'd0;
    end else if (load_bubble && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Captures the execute-stage results: GPR write, HI/LO write, load/store opcode, address and store data.
- Inserts a bubble toward MEM when EX is stalled and MEM is not.
- Holds the multi-cycle MADD/MSUB intermediate product and step count, and returns them to the execute stage on the following cycle.

Parameters:
- ALUOP_W, 8, width of the ALU opcode bus.
- REG_W, 32, data word width.
- RADDR_W, 5, register-file address width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- stall  input  6  pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled.
- flush  input  1  synchronous kill of the MEM-bound slot.
- ex_writeReg  input  1  GPR write enable from EX.
- ex_writeAddr  input  RADDR_W  GPR destination.
- ex_writeData  input  REG_W  GPR write data.
- ex_wHiLo  input  1  HI/LO write enable.
- ex_hiData  input  REG_W  HI write data.
- ex_loData  input  REG_W  LO write data.
- ex_aluOp  input  ALUOP_W  opcode, used by MEM for load/store selection.
- ex_mem_addr  input  REG_W  effective memory address.
- ex_opNum2  input  REG_W  store data.
- hilo_i  input  2*REG_W  intermediate MADD/MSUB product from EX.
- count_i  input  2  MADD/MSUB step count from EX.
- mem_writeReg, mem_writeAddr, mem_writeData, mem_wHiLo, mem_hiData, mem_loData, mem_aluOp, mem_mem_addr, mem_opNum2  output  (widths as the matching ex_ inputs)  registered copies delivered to MEM.
- hilo_o  output  2*REG_W  held intermediate product, fed back to EX.
- count_o  output  2  held step count, fed back to EX.
- mem_valid  output  1  1 = MEM slot holds a real instruction; 0 = bubble.

Behaviour:
- Reset (rst=0, asynchronous):
  - every output goes to 0 immediately: enables 0, addresses 0, data 0, aluOp 0 (NOP), hilo_o 0, count_o 0, mem_valid 0.
  - Held until the first rising clk edge after rst returns to 1.
- Rising-edge update rules, evaluated in this priority order:
  1. flush=1: MEM slot loads a bubble (all mem_* = 0, mem_valid=0); hilo_o=0; count_o=0. Flush overrides stall.
  2. stall[3]=1 and stall[4]=0 (EX stalled, MEM free):
     - MEM slot loads a bubble.
     - hilo_o <= hilo_i and count_o <= count_i, so a multi-cycle MADD/MSUB resumes with its partial result.
  3. stall[3]=0 (EX advancing):
     - MEM slot loads all ex_* inputs; mem_valid=1.
     - hilo_o <= 0; count_o <= 0.
  4. stall[3]=1 and stall[4]=1: all registers hold.
- Latency: exactly one cycle from ex_* to mem_*. The hilo/count feedback also has one-cycle latency.
- Bubble contents: writeReg=0, wHiLo=0, aluOp=0, all data fields 0. MEM must never observe stale enables.
- No arithmetic in this block; all fields are passed through bit-exact.
- count_i=2'b11 is never produced by EX; it is registered as-is with no special handling.
- flush and stall[3]=0 in the same cycle: flush wins; no write enable reaches MEM.
- Reset asserted mid-MADD: count_o and hilo_o clear asynchronously, and the sequence restarts at count 0.

Optional Feature:
- Macro: EX_MEM_BUBBLE_CNT_EN.
- Defined:
  - adds output bubble_cnt (32 bits) and input bubble_cnt_clr (1 bit).
  - bubble_cnt increments on every edge that loads a bubble by rule 1 or rule 2.
  - It saturates at 32'hFFFFFFFF, is cleared by bubble_cnt_clr (clear wins over increment), and is reset to 0.
- Undefined: neither port exists; no counter logic is built.

Test Plan:
1. rst=0 mid-cycle with all inputs nonzero -> all outputs 0 immediately, before any clk edge; after release, the first edge with stall=0 captures the inputs.
2. stall=6'b0, ex_writeReg=1, ex_writeAddr=5'd8, ex_writeData=32'h1234_5678 -> next cycle mem_writeReg=1, mem_writeAddr=8, mem_writeData=32'h1234_5678, mem_valid=1.
3. MADD sequence:
   - Cycle 1: stall=6'b001111, count_i=2'b01, hilo_i=64'h0000_0001_FFFF_FFFE -> next cycle mem_writeReg=0, mem_wHiLo=0, mem_valid=0, count_o=2'b01, hilo_o=64'h0000_0001_FFFF_FFFE.
   - Cycle 2: stall=0 -> count_o=0, hilo_o=0, EX results captured.
4. stall=6'b011111 for 3 cycles after capturing writeData=32'hDEAD_BEEF -> mem_* unchanged across all 3 cycles.
5. flush=1 with stall=0, ex_wHiLo=1, ex_aluOp=8'hE3 -> mem_wHiLo=0, mem_aluOp=0, mem_valid=0, count_o=0.
6. With EX_MEM_BUBBLE_CNT_EN defined: 5 bubble cycles then bubble_cnt_clr=1 together with a bubble -> bubble_cnt reads 5, then 0.
